// File: rtl/mac_acc18_stream.sv
// Streaming signed Q4.4 dot-product accumulator: product stage, saturating 18-bit
// accumulator with a two-state vector FSM, and a valid/ready result register.
module mac_acc18_stream #(
    parameter int unsigned LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [7:0]       a_in,
    input  logic signed [7:0]       b_in,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic signed [17:0]      acc_out,
    output logic                    out_sat,
    output logic [LEN_W-1:0]        out_len,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned PROD_W = 16;
    localparam int unsigned ACC_W  = 18;
    localparam int unsigned SUM_W  = 19;

    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'(131071);
    localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(-131072);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t state, state_nx;

    logic signed [PROD_W-1:0] a_ext_c, b_ext_c, prod_c;
    logic signed [PROD_W-1:0] p_prod;
    logic                     p_valid, p_last;

    logic signed [ACC_W-1:0]  acc;
    logic                     sticky;
    logic [LEN_W-1:0]         count;

    logic                     stall_c, acc_en_c, complete_c, clamp_c;
    logic signed [SUM_W-1:0]  base_c, sum_c;
    logic signed [ACC_W-1:0]  clamped_c;
    logic [LEN_W-1:0]         cnt_inc_c;

    // A finished vector may only sit in P while the output register is still occupied.
    assign stall_c    = p_valid & p_last & out_valid & ~out_ready;
    assign in_ready   = ~stall_c;
    assign acc_en_c   = p_valid & ~stall_c;
    assign complete_c = acc_en_c & p_last;

    assign a_ext_c = PROD_W'(a_in);
    assign b_ext_c = PROD_W'(b_in);
    assign prod_c  = a_ext_c * b_ext_c;

    // Saturating sum; IDLE means no partial sum, so the beat starts a fresh vector.
    always_comb begin
        base_c    = '0;
        clamp_c   = 1'b0;
        clamped_c = '0;
        if (state == ACCUM) begin
            base_c = SUM_W'(acc);
        end
        sum_c = base_c + SUM_W'(p_prod);
        if (sum_c > ACC_MAX) begin
            clamp_c   = 1'b1;
            clamped_c = ACC_W'(ACC_MAX);
        end else if (sum_c < ACC_MIN) begin
            clamp_c   = 1'b1;
            clamped_c = ACC_W'(ACC_MIN);
        end else begin
            clamped_c = ACC_W'(sum_c);
        end
    end

    assign cnt_inc_c = (count == {LEN_W{1'b1}}) ? count : count + LEN_W'(1);

    always_comb begin
        state_nx = state;
        if (acc_en_c) begin
            state_nx = p_last ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath: product stage, accumulator, and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid   <= 1'b0;
            p_last    <= 1'b0;
            p_prod    <= '0;
            acc       <= '0;
            sticky    <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            acc_out   <= '0;
            out_sat   <= 1'b0;
            out_len   <= '0;
        end else begin
            if (!stall_c) begin
                p_valid <= in_valid;
                p_last  <= in_last;
                p_prod  <= prod_c;
            end

            if (acc_en_c) begin
                if (p_last) begin
                    acc    <= '0;
                    sticky <= 1'b0;
                    count  <= '0;
                end else begin
                    acc    <= clamped_c;
                    sticky <= sticky | clamp_c;
                    count  <= cnt_inc_c;
                end
            end

            // A completion overrides the handshake so back-to-back results leave no bubble.
            if (complete_c) begin
                out_valid <= 1'b1;
                acc_out   <= clamped_c;
                out_sat   <= sticky | clamp_c;
                out_len   <= cnt_inc_c;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_acc18_stream.sv
// Directed bench for mac_acc18_stream with hand-computed expected results.
module tb_mac_acc18_stream;

    localparam int unsigned LEN_W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic signed [7:0]      a_in, b_in;
    logic                   in_valid, in_last, in_ready;
    logic signed [17:0]     acc_out;
    logic                   out_sat;
    logic [LEN_W-1:0]       out_len;
    logic                   out_valid, out_ready;

    int checks = 0;
    int errors = 0;

    mac_acc18_stream #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .out_sat   (out_sat),
        .out_len   (out_len),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int a, input int b, input bit last);
        a_in     = 8'(a);
        b_in     = 8'(b);
        in_last  = last;
        in_valid = 1'b1;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        a_in = '0; b_in = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_acc", int'($signed(acc_out)), 0);
        chk("rst_len", int'(out_len), 0);
        chk("rst_sat", int'(out_sat), 0);
        rst = 1'b0;

        // single beat 1.0 * 1.0
        send(16, 16, 1);
        idle();
        chk("t1_valid", int'(out_valid), 1);
        chk("t1_acc", int'($signed(acc_out)), 256);
        chk("t1_len", int'(out_len), 1);
        chk("t1_sat", int'(out_sat), 0);
        drain();
        chk("t1_drained", int'(out_valid), 0);

        // 1*(1 - 2 + 0.5 + 0.25) with a gap mid-vector
        send(16, 16, 0);
        send(16, -32, 0);
        idle();
        send(16, 8, 0);
        send(16, 4, 1);
        idle();
        chk("t2_valid", int'(out_valid), 1);
        chk("t2_acc", int'($signed(acc_out)), -64);
        chk("t2_len", int'(out_len), 4);
        chk("t2_sat", int'(out_sat), 0);
        drain();

        // positive and negative saturation
        for (int i = 0; i < 8; i++) send(127, 127, 0);
        send(127, 127, 1);
        idle();
        chk("t3p_acc", int'($signed(acc_out)), 131071);
        chk("t3p_sat", int'(out_sat), 1);
        chk("t3p_len", int'(out_len), 9);
        drain();
        for (int i = 0; i < 8; i++) send(-128, 127, 0);
        send(-128, 127, 1);
        idle();
        chk("t3n_acc", int'($signed(acc_out)), -131072);
        chk("t3n_sat", int'(out_sat), 1);
        drain();

        // backpressure with three one-beat vectors
        send(1, 1, 1);
        send(1, 2, 1);
        a_in = 8'(1); b_in = 8'(3); in_valid = 1'b1; in_last = 1'b1;
        #1;
        chk("t4_stall_ready", int'(in_ready), 0);
        chk("t4_held_acc", int'($signed(acc_out)), 1);
        chk("t4_sat_cleared", int'(out_sat), 0);
        step();
        chk("t4_stall_ready2", int'(in_ready), 0);
        chk("t4_held_acc2", int'($signed(acc_out)), 1);
        chk("t4_held_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        #1;
        chk("t4_release_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("t4_r2_valid", int'(out_valid), 1);
        chk("t4_r2_acc", int'($signed(acc_out)), 2);
        step();
        chk("t4_r3_valid", int'(out_valid), 1);
        chk("t4_r3_acc", int'($signed(acc_out)), 3);
        step();
        chk("t4_empty", int'(out_valid), 0);

        // completion coinciding with handshake, full throughput
        send(1, 4, 1);
        send(1, 5, 1);
        chk("t5_a_valid", int'(out_valid), 1);
        chk("t5_a_acc", int'($signed(acc_out)), 4);
        send(1, 6, 1);
        chk("t5_b_valid", int'(out_valid), 1);
        chk("t5_b_acc", int'($signed(acc_out)), 5);
        idle();
        chk("t5_c_valid", int'(out_valid), 1);
        chk("t5_c_acc", int'($signed(acc_out)), 6);
        idle();
        chk("t5_empty", int'(out_valid), 0);
        out_ready = 1'b0;

        // beat counter saturates
        for (int i = 0; i < 259; i++) send(0, 0, 0);
        send(0, 0, 1);
        idle();
        chk("len_sat", int'(out_len), 255);
        chk("len_acc", int'($signed(acc_out)), 0);
        drain();

        // reset mid-vector with a held result
        send(1, 7, 1);
        idle();
        chk("t6_held_acc", int'($signed(acc_out)), 7);
        send(16, 16, 0);
        send(16, 16, 0);
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        step();
        rst = 1'b0;
        chk("t6_rst_valid", int'(out_valid), 0);
        chk("t6_rst_acc", int'($signed(acc_out)), 0);
        chk("t6_rst_ready", int'(in_ready), 1);
        send(16, 16, 1);
        idle();
        chk("t6_valid", int'(out_valid), 1);
        chk("t6_acc", int'($signed(acc_out)), 256);
        chk("t6_len", int'(out_len), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
